// File: rtl/seq_sched_pkg.sv
// Shared constants for the Moore sequence scheduler: FSM state codes,
// default pattern, and the detector's cleared-state encoding.
package seq_sched_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    localparam int               DEF_PAT_LEN = 3;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 3'b101;

    // Detector state = {fill count, bit history}; S0 is empty history, fill 0.
    localparam int DET_FILL_S0 = 0;

endpackage

// File: rtl/moore_seq_core.sv
// Moore serial pattern detector with overlap: state is the last PAT_LEN bits
// plus a fill count, and the registered output flags a full-history match.
module moore_seq_core
    import seq_sched_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    localparam int FILL_W = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               dout_q, dout_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clr) begin
            hist_d = '0;
            fill_d = FILL_W'(DET_FILL_S0);
        end else if (en) begin
            hist_d = {hist_q[PAT_LEN-2:0], din};
            if (fill_q != FILL_W'(PAT_LEN)) begin
                fill_d = fill_q + 1'b1;
            end
        end
        // Output is a pure function of the next state, held in a flop.
        dout_d = (fill_d == FILL_W'(PAT_LEN)) && (hist_d == PATTERN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= FILL_W'(DET_FILL_S0);
            dout_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/moore_seq_scheduler.sv
// Arbitrates NUM_REQ frame sources onto one Moore pattern detector and reports
// the per-frame overlapping match count. Define FIXED_PRIO_EN for fixed priority.
module moore_seq_scheduler
    import seq_sched_pkg::*;
#(
    parameter int                 NUM_REQ = 4,
    parameter int                 DATA_W  = 8,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    localparam int                ID_W    = $clog2(NUM_REQ),
    localparam int                CNT_W   = $clog2(DATA_W + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      match_any
);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               match_any_q, match_any_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [ID_W-1:0]    win_id_q, win_id_d;
    logic [CNT_W-1:0]   acc_q, acc_d;

    logic               found;
    logic [ID_W-1:0]    win;
    logic               det_clr, det_en, det_out;

`ifndef FIXED_PRIO_EN
    logic [ID_W-1:0]    ptr_q, ptr_d;
`endif

    always_comb begin
        found = 1'b0;
        win   = '0;
`ifdef FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                win   = ID_W'(i);
            end
        end
`else
        // Scan starting at the pointer so the last winner goes to the back.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[(int'(ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        match_cnt_d = match_cnt_q;
        match_any_d = match_any_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        win_id_d    = win_id_q;
        acc_d       = acc_q;
        det_clr     = 1'b0;
        det_en      = 1'b0;
`ifndef FIXED_PRIO_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_SHIFT;
                    gnt_d[win] = 1'b1;
                    busy_d     = 1'b1;
                    shreg_d    = req_data[int'(win)*DATA_W +: DATA_W];
                    win_id_d   = win;
                    bit_cnt_d  = '0;
                    acc_d      = '0;
                    det_clr    = 1'b1;
`ifndef FIXED_PRIO_EN
                    ptr_d      = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`endif
                end
            end
            ST_SHIFT: begin
                det_en    = 1'b1;
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                // Detector output lags one edge, so the first shift edge has nothing to count.
                if (bit_cnt_q != '0 && det_out) begin
                    acc_d = acc_q + 1'b1;
                end
                if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d     = ST_REPORT;
                done_d      = 1'b1;
                done_id_d   = win_id_q;
                match_cnt_d = acc_q + CNT_W'(det_out);
                match_any_d = (match_cnt_d != '0);
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            done_id_q   <= '0;
            match_cnt_q <= '0;
            match_any_q <= 1'b0;
            bit_cnt_q   <= '0;
`ifndef FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            match_cnt_q <= match_cnt_d;
            match_any_q <= match_any_d;
            bit_cnt_q   <= bit_cnt_d;
`ifndef FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shreg_q  <= shreg_d;
        win_id_q <= win_id_d;
        acc_q    <= acc_d;
    end

    moore_seq_core #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (det_clr),
        .en   (det_en),
        .din  (shreg_q[DATA_W-1]),
        .dout (det_out)
    );

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;
    assign match_cnt = match_cnt_q;
    assign match_any = match_any_q;

endmodule

// File: tb/tb_moore_seq_scheduler.sv
// Directed bench for moore_seq_scheduler (NUM_REQ=4, DATA_W=8, PATTERN=101).
module tb_moore_seq_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [DATA_W-1:0]         data [NUM_REQ];
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      busy, done, match_any;
    logic [1:0]                done_id;
    logic [3:0]                match_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    assign req_data = {data[3], data[2], data[1], data[0]};

    always #5 clk = ~clk;

    moore_seq_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt),
        .match_any (match_any)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after REPORT.
    task automatic do_frame(input logic [3:0] rq, input bit hold, input int exp_id,
                            input int exp_cnt, input string tag);
        bit bad;
        bad = 1'b0;
        req = rq;
        @(negedge clk);
        check({tag, ".gnt"}, 32'(gnt), 32'd1 << exp_id);
        check({tag, ".busy_on"}, 32'(busy), 32'd1);
        if (!hold) req = '0;
        repeat (DATA_W) begin
            @(negedge clk);
            if (done !== 1'b0 || gnt !== '0 || busy !== 1'b1) bad = 1'b1;
        end
        check({tag, ".mid"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".id"}, 32'(done_id), 32'(exp_id));
        check({tag, ".cnt"}, 32'(match_cnt), 32'(exp_cnt));
        check({tag, ".any"}, 32'(match_any), 32'(exp_cnt != 0));
        @(negedge clk);
        check({tag, ".done_off"}, 32'(done), 32'd0);
        check({tag, ".busy_off"}, 32'(busy), 32'd0);
        check({tag, ".cnt_hold"}, 32'(match_cnt), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Hand-computed 101-match counts: AA->3, 00->0, 05->1, 2D->2.
    int cnt_of [NUM_REQ] = '{3, 0, 1, 2};
`ifdef FIXED_PRIO_EN
    int rr_ids [5] = '{0, 0, 0, 0, 0};
`else
    int rr_ids [5] = '{0, 1, 2, 3, 0};
`endif

    initial begin
        bit bad;
        data[0] = 8'hAA; data[1] = 8'h00; data[2] = 8'h05; data[3] = 8'h2D;
        #12;
        check("rst.gnt", 32'(gnt), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.id", 32'(done_id), 32'd0);
        check("rst.cnt", 32'(match_cnt), 32'd0);
        check("rst.any", 32'(match_any), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle.gnt", 32'(gnt), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);

        do_frame(4'b0001, 1'b0, 0, 3, "t1");
        data[1] = 8'h00;
        do_frame(4'b0010, 1'b0, 1, 0, "t2a");
        data[1] = 8'h05;
        do_frame(4'b0010, 1'b0, 1, 1, "t2b");
        data[1] = 8'h02;
        do_frame(4'b0010, 1'b0, 1, 0, "t4a");
        data[1] = 8'h80;
        do_frame(4'b0010, 1'b0, 1, 0, "t4b");

        data[1] = 8'h00;
        do_reset();
        for (int k = 0; k < 5; k++)
            do_frame(4'b1111, (k != 4), rr_ids[k], cnt_of[rr_ids[k]], $sformatf("t3.%0d", k));

        do_frame(4'b1000, 1'b1, 3, 2, "t6a");
        do_frame(4'b1000, 1'b0, 3, 2, "t6b");

        // Leave the RR pointer at 3 so the post-reset grant shows it was cleared.
        do_frame(4'b0100, 1'b0, 2, 1, "t5pre");
        req = 4'b0100;
        @(negedge clk);
        check("t5.gnt", 32'(gnt), 32'b0100);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5.rst_gnt", 32'(gnt), 32'd0);
        check("t5.rst_busy", 32'(busy), 32'd0);
        check("t5.rst_done", 32'(done), 32'd0);
        check("t5.rst_cnt", 32'(match_cnt), 32'd0);
        #1 rst = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("t5.no_done", 32'(bad), 32'd0);
        data[1] = 8'hAA;
        do_frame(4'b1010, 1'b0, 1, 3, "t5post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
